serial_addsub: RTL and testbench

- Parametrised, sequential successor to the 1-bit half-adder datapath in the TinyTapeout top.
- Adds or subtracts two WIDTH-bit operands one DIGIT-bit slice per cycle, LSB first, with a registered carry.
- Reports result, carry-out and signed overflow with a start/busy/done handshake.
- Sits behind tt_um_vlsi, which maps ui_in/uio_in to operands and result to uo_out.

---
 rtl/serial_addsub_pkg.sv | 17 +
 rtl/serial_addsub_digit.sv | 38 +++
 rtl/serial_addsub.sv | 143 ++++++++++++++
 tb/tb_serial_addsub.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/serial_addsub_pkg.sv
// Shared types and elaboration helpers for the digit-serial adder/subtractor.
package serial_addsub_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // True when the slice width is legal for the given operand width.
   function automatic bit digit_ok(input int unsigned width, input int unsigned digit);
      if (digit < 1) return 1'b0;
      if (digit > width) return 1'b0;
      return (width % digit) == 0;
   endfunction

endpackage

// File: rtl/serial_addsub_digit.sv
// Combinational DIGIT-bit ripple adder built from chained XOR/AND half-adder pairs.
module addsub_digit #(
   parameter int unsigned DIGIT = 1
) (
   input  logic [DIGIT-1:0] a_d,
   input  logic [DIGIT-1:0] b_d,
   input  logic             cin,
   output logic [DIGIT-1:0] s_d,
   output logic             cout,
   output logic             c_msb_in
);

   logic [DIGIT:0]   c;
   logic [DIGIT-1:0] p;
   logic [DIGIT-1:0] g;
   logic [DIGIT-1:0] pc;

   // Two half adders per bit; the OR of their carries forms the full-adder carry.
   always_comb begin
      c    = '0;
      p    = '0;
      g    = '0;
      pc   = '0;
      s_d  = '0;
      c[0] = cin;
      for (int i = 0; i < int'(DIGIT); i++) begin
         p[i]   = a_d[i] ^ b_d[i];
         g[i]   = a_d[i] & b_d[i];
         s_d[i] = p[i] ^ c[i];
         pc[i]  = p[i] & c[i];
         c[i+1] = g[i] | pc[i];
      end
   end

   assign cout     = c[DIGIT];
   assign c_msb_in = c[DIGIT-1];

endmodule

// File: rtl/serial_addsub.sv
// Digit-serial add/subtract unit: one DIGIT-bit slice per cycle, LSB first, with
// start/busy/done handshake and one-shot loading of sum/cout/ovf on completion.
module serial_addsub
   import serial_addsub_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DIGIT = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int unsigned DIGIT_NZ = (DIGIT == 0) ? 1 : DIGIT;
   localparam int unsigned N        = WIDTH / DIGIT_NZ;
   localparam int unsigned CNT_W    = (N < 1) ? 1 : $clog2(N + 1);

   if (!digit_ok(WIDTH, DIGIT)) begin : g_bad_digit
      $fatal(1, "serial_addsub: DIGIT must be >= 1 and divide WIDTH exactly");
   end

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] sh_q, sh_d;
   logic             carry_q, carry_d;
   logic             cmsb_q, cmsb_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             cout_q, cout_d;
   logic             ovf_q, ovf_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   logic [DIGIT-1:0] slice_s;
   logic             slice_cout;
   logic             slice_cmsb;

   addsub_digit #(
      .DIGIT (DIGIT)
   ) u_digit (
      .a_d      (a_q[DIGIT-1:0]),
      .b_d      (b_q[DIGIT-1:0]),
      .cin      (carry_q),
      .s_d      (slice_s),
      .cout     (slice_cout),
      .c_msb_in (slice_cmsb)
   );

   // Next-state, datapath and output decode.
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      sh_d    = sh_q;
      carry_d = carry_q;
      cmsb_d  = cmsb_q;
      cnt_d   = cnt_q;
      sum_d   = sum_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;

      unique case (state_q)
         IDLE, DONE: begin
            if (state_q == DONE) state_d = IDLE;
            if (start) begin
               state_d = RUN;
               a_d     = a;
               b_d     = b ^ {WIDTH{sub}};
               carry_d = sub;
               cmsb_d  = 1'b0;
               cnt_d   = '0;
               sh_d    = '0;
            end
         end
         RUN: begin
            if (cnt_q < CNT_W'(N)) begin
               a_d     = a_q >> DIGIT;
               b_d     = b_q >> DIGIT;
               sh_d    = (sh_q >> DIGIT) | (WIDTH'(slice_s) << (WIDTH - DIGIT));
               carry_d = slice_cout;
               cnt_d   = cnt_q + CNT_W'(1);
               if (cnt_q == CNT_W'(N - 1)) cmsb_d = slice_cmsb;
            end else begin
               // All slices done: publish results in one shot.
               state_d = DONE;
               sum_d   = sh_q;
               cout_d  = carry_q;
               ovf_d   = carry_q ^ cmsb_q;
            end
         end
         default: state_d = IDLE;
      endcase

      busy_d = (state_q == RUN) && (state_d == RUN);
      done_d = (state_d == DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         sh_q    <= '0;
         carry_q <= 1'b0;
         cmsb_q  <= 1'b0;
         cnt_q   <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sh_q    <= sh_d;
         carry_q <= carry_d;
         cmsb_q  <= cmsb_d;
         cnt_q   <= cnt_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign sum  = sum_q;
   assign cout = cout_q;
   assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_addsub.sv
// Bench for serial_addsub at DIGIT = 1, 4 and 8 against an arithmetic reference model.
module tb_serial_addsub;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start;
   logic       sub_i;
   logic [7:0] a_i;
   logic [7:0] b_i;

   logic       busy_w [3];
   logic       done_w [3];
   logic [7:0] sum_w  [3];
   logic       cout_w [3];
   logic       ovf_w  [3];

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   serial_addsub #(.WIDTH(8), .DIGIT(1)) u_d1 (
      .clk(clk), .rst_n(rst_n), .start(start), .sub(sub_i), .a(a_i), .b(b_i),
      .busy(busy_w[0]), .done(done_w[0]), .sum(sum_w[0]), .cout(cout_w[0]), .ovf(ovf_w[0]));
   serial_addsub #(.WIDTH(8), .DIGIT(4)) u_d4 (
      .clk(clk), .rst_n(rst_n), .start(start), .sub(sub_i), .a(a_i), .b(b_i),
      .busy(busy_w[1]), .done(done_w[1]), .sum(sum_w[1]), .cout(cout_w[1]), .ovf(ovf_w[1]));
   serial_addsub #(.WIDTH(8), .DIGIT(8)) u_d8 (
      .clk(clk), .rst_n(rst_n), .start(start), .sub(sub_i), .a(a_i), .b(b_i),
      .busy(busy_w[2]), .done(done_w[2]), .sum(sum_w[2]), .cout(cout_w[2]), .ovf(ovf_w[2]));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference arithmetic: modular result, unsigned carry/no-borrow, signed range overflow.
   function automatic void ref_calc(input logic [7:0] x, input logic [7:0] y, input logic s,
                                    output logic [7:0] r, output logic c, output logic v);
      int ux, uy, sx, sy, sr;
      ux = int'(x);
      uy = int'(y);
      sx = (ux > 127) ? ux - 256 : ux;
      sy = (uy > 127) ? uy - 256 : uy;
      if (s) begin
         r  = 8'((ux - uy) & 255);
         c  = (ux >= uy);
         sr = sx - sy;
      end else begin
         r  = 8'((ux + uy) & 255);
         c  = (ux + uy) > 255;
         sr = sx + sy;
      end
      v = (sr > 127) || (sr < -128);
   endfunction

   // Transaction model: cycles remaining until the result is published.
   int         nn    [3] = '{8, 2, 1};
   int         rem   [3] = '{0, 0, 0};
   logic [7:0] e_sum [3] = '{8'h0, 8'h0, 8'h0};
   logic       e_cout[3] = '{1'b0, 1'b0, 1'b0};
   logic       e_ovf [3] = '{1'b0, 1'b0, 1'b0};
   logic       e_done[3] = '{1'b0, 1'b0, 1'b0};
   logic [7:0] p_sum [3];
   logic       p_cout[3];
   logic       p_ovf [3];

   always @(posedge clk or negedge rst_n) begin
      for (int i = 0; i < 3; i++) begin
         if (!rst_n) begin
            rem[i] = 0; e_sum[i] = 8'h0; e_cout[i] = 1'b0; e_ovf[i] = 1'b0; e_done[i] = 1'b0;
         end else if (rem[i] > 0) begin
            rem[i]    = rem[i] - 1;
            e_done[i] = (rem[i] == 0);
            if (rem[i] == 0) begin
               e_sum[i] = p_sum[i]; e_cout[i] = p_cout[i]; e_ovf[i] = p_ovf[i];
            end
         end else begin
            e_done[i] = 1'b0;
            if (start) begin
               rem[i] = nn[i] + 1;
               ref_calc(a_i, b_i, sub_i, p_sum[i], p_cout[i], p_ovf[i]);
            end
         end
      end
   end

   always @(negedge clk) begin
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("d%0d busy", i), 32'(busy_w[i]), 32'(rem[i] >= 1 && rem[i] <= nn[i]));
         chk($sformatf("d%0d done", i), 32'(done_w[i]), 32'(e_done[i]));
         chk($sformatf("d%0d sum", i),  32'(sum_w[i]),  32'(e_sum[i]));
         chk($sformatf("d%0d cout", i), 32'(cout_w[i]), 32'(e_cout[i]));
         chk($sformatf("d%0d ovf", i),  32'(ovf_w[i]),  32'(e_ovf[i]));
      end
   end

   task automatic op(input logic [7:0] aa, input logic [7:0] bb, input logic s);
      a_i = aa; b_i = bb; sub_i = s; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_d1(input string name);
      int c;
      c = 0;
      while (!done_w[0] && c < 20) begin
         @(negedge clk);
         c++;
      end
      chk({name, " latency"}, 32'(c), 32'd9);
   endtask

   task automatic chk_res(input string name, input logic [7:0] s, input logic c, input logic v);
      chk({name, " sum"},  32'(sum_w[0]),  32'(s));
      chk({name, " cout"}, 32'(cout_w[0]), 32'(c));
      chk({name, " ovf"},  32'(ovf_w[0]),  32'(v));
   endtask

   initial begin
      logic [7:0] r;
      logic       c, v;
      int         first[3];
      int         bcnt, dcnt;
      logic [7:0] seen;

      rst_n = 1'b0; start = 1'b0; sub_i = 1'b0; a_i = 8'h0; b_i = 8'h0;

      ref_calc(8'h7F, 8'h01, 1'b0, r, c, v);
      chk("model 7F+01", {23'd0, r, c}, {23'd0, 8'h80, 1'b0}); chk("model 7F+01 ovf", 32'(v), 32'd1);
      ref_calc(8'h05, 8'h07, 1'b1, r, c, v);
      chk("model 05-07", {22'd0, r, c, v}, {22'd0, 8'hFE, 1'b0, 1'b0});
      ref_calc(8'h80, 8'h01, 1'b1, r, c, v);
      chk("model 80-01", {22'd0, r, c, v}, {22'd0, 8'h7F, 1'b1, 1'b1});

      repeat (2) @(negedge clk);
      chk_res("reset", 8'h00, 1'b0, 1'b0);
      chk("reset busy", 32'(busy_w[0]), 32'd0);
      chk("reset done", 32'(done_w[0]), 32'd0);
      #2 rst_n = 1'b1;
      @(negedge clk);

      // 0x0F + 0x01: latency per slice width and busy length
      op(8'h0F, 8'h01, 1'b0);
      first = '{-1, -1, -1};
      bcnt  = 0;
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         if (busy_w[0]) bcnt++;
         for (int i = 0; i < 3; i++) if (done_w[i] && first[i] < 0) first[i] = k;
      end
      chk("t1 d1 latency", 32'(first[0]), 32'd9);
      chk("t1 d4 latency", 32'(first[1]), 32'd3);
      chk("t1 d8 latency", 32'(first[2]), 32'd2);
      chk("t1 busy cycles", 32'(bcnt), 32'd8);
      chk_res("t1", 8'h10, 1'b0, 1'b0);

      // carry out, then back-to-back start held in the DONE cycle
      op(8'hFF, 8'h01, 1'b0);
      wait_d1("t2a");
      chk_res("t2a", 8'h00, 1'b1, 1'b0);
      op(8'h7F, 8'h01, 1'b0);
      wait_d1("t2b");
      chk_res("t2b", 8'h80, 1'b0, 1'b1);

      // subtraction with borrow, then signed overflow
      op(8'h05, 8'h07, 1'b1);
      wait_d1("t3a");
      chk_res("t3a", 8'hFE, 1'b0, 1'b0);
      op(8'h80, 8'h01, 1'b1);
      wait_d1("t3b");
      chk_res("t3b", 8'h7F, 1'b1, 1'b1);

      // start while running is ignored
      repeat (12) @(negedge clk);
      op(8'h10, 8'h20, 1'b0);
      repeat (3) @(negedge clk);
      a_i = 8'hAA; b_i = 8'h55; sub_i = 1'b1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      dcnt = 0; seen = 8'h00;
      for (int k = 0; k < 15; k++) begin
         @(negedge clk);
         if (done_w[0]) begin dcnt++; seen = sum_w[0]; end
      end
      chk("t4 done pulses", 32'(dcnt), 32'd1);
      chk("t4 sum", 32'(seen), 32'h30);

      // reset mid-run aborts at once
      repeat (12) @(negedge clk);
      op(8'h33, 8'h11, 1'b0);
      repeat (4) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk_res("t5 async", 8'h00, 1'b0, 1'b0);
      chk("t5 busy", 32'(busy_w[0]), 32'd0);
      chk("t5 done", 32'(done_w[0]), 32'd0);
      chk("t5 d4 sum", 32'(sum_w[1]), 32'h00);
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b1;
      dcnt = 0;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         if (done_w[0]) dcnt++;
      end
      chk("t5 no done", 32'(dcnt), 32'd0);
      op(8'h01, 8'h02, 1'b0);
      wait_d1("t5b");
      chk_res("t5b", 8'h03, 1'b0, 1'b0);

      // operand sweep checked by the model every cycle
      repeat (3) @(negedge clk);
      for (int k = 0; k < 1000; k++) begin
         op(8'($urandom), 8'($urandom), 1'($urandom));
         repeat (10) @(negedge clk);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
